// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for a single shared memory bus.
// Round-robin on ties, bounded bursts per grant, fixed wait states per transfer.
module bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_BURST   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_grant,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_r,
    input  logic        dma_w,
    output logic [7:0]  dma_rdata,
    output logic        dma_ready,
    output logic        dma_grant,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_r,
    output logic        mem_w,
    output logic        bus_err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;
    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_DMA = 1'b1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_r_q, mem_r_d;
    logic        mem_w_q, mem_w_d;
    logic        cpu_grant_q, cpu_grant_d;
    logic        dma_grant_q, dma_grant_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic        dma_ready_q, dma_ready_d;
    logic        bus_err_q, bus_err_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;

    logic        start;
    logic        sel_dma;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_r;
    logic        sel_w;
    logic        own_req;
    logic        oth_req;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_r_d      = mem_r_q;
        mem_w_d      = mem_w_q;
        cpu_grant_d  = cpu_grant_q;
        dma_grant_d  = dma_grant_q;
        cpu_ready_d  = 1'b0;
        dma_ready_d  = 1'b0;
        bus_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        start        = 1'b0;
        sel_dma      = owner_q;
        own_req      = (owner_q == OWN_DMA) ? dma_req : cpu_req;
        oth_req      = (owner_q == OWN_DMA) ? cpu_req : dma_req;

        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    start        = 1'b1;
                    sel_dma      = dma_req && (!cpu_req || last_grant_q == OWN_CPU);
                    last_grant_d = sel_dma;
                    burst_cnt_d  = 4'd1;
                end
            end
            ACCESS: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = DONE;
                    mem_r_d     = 1'b0;
                    mem_w_d     = 1'b0;
                    cpu_ready_d = (owner_q == OWN_CPU);
                    dma_ready_d = (owner_q == OWN_DMA);
                    if (mem_r_q && owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    if (mem_r_q && owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            DONE: begin
                // Keep the bus only while the other side is idle or the burst quota remains.
                if (own_req && (burst_cnt_q < BURST_MAX || !oth_req)) begin
                    start = 1'b1;
                    if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    state_d     = IDLE;
                    cpu_grant_d = 1'b0;
                    dma_grant_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_r_d     = 1'b0;
                mem_w_d     = 1'b0;
                cpu_grant_d = 1'b0;
                dma_grant_d = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase

        sel_addr  = sel_dma ? dma_addr  : cpu_addr;
        sel_wdata = sel_dma ? dma_wdata : cpu_wdata;
        sel_r     = sel_dma ? dma_r     : cpu_r;
        sel_w     = sel_dma ? dma_w     : cpu_w;

        if (start) begin
            owner_d     = sel_dma;
            cpu_grant_d = !sel_dma;
            dma_grant_d = sel_dma;
            mem_addr_d  = sel_addr;
            mem_wdata_d = sel_wdata;
            wait_cnt_d  = 3'd0;
            // Exactly one of r/w is a real transfer; anything else completes at once as an error.
            if (sel_r != sel_w) begin
                state_d = ACCESS;
                mem_r_d = sel_r;
                mem_w_d = sel_w;
            end else begin
                state_d     = DONE;
                mem_r_d     = 1'b0;
                mem_w_d     = 1'b0;
                cpu_ready_d = !sel_dma;
                dma_ready_d = sel_dma;
                bus_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DMA;
            burst_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_r_q      <= 1'b0;
            mem_w_q      <= 1'b0;
            cpu_grant_q  <= 1'b0;
            dma_grant_q  <= 1'b0;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            bus_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_r_q      <= mem_r_d;
            mem_w_q      <= mem_w_d;
            cpu_grant_q  <= cpu_grant_d;
            dma_grant_q  <= dma_grant_d;
            cpu_ready_q  <= cpu_ready_d;
            dma_ready_q  <= dma_ready_d;
            bus_err_q    <= bus_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_r     = mem_r_q;
    assign mem_w     = mem_w_q;
    assign cpu_grant = cpu_grant_q;
    assign dma_grant = dma_grant_q;
    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;
    assign bus_err   = bus_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: two parameterisations driven by shared stimulus and checked
// against a transfer-schedule model that books each transfer's cycles in a timeline.
module tb_bus_arbiter;

    localparam int W0 = 1;
    localparam int MB0 = 4;
    localparam int W1 = 0;
    localparam int MB1 = 2;
    localparam int NCYC = 2000;
    localparam int ASZ = NCYC + 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req, cpu_r, cpu_w, dma_req, dma_r, dma_w;
    logic [15:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, mem_rdata;

    logic [1:0][7:0]  d_cpu_rdata, d_dma_rdata, d_mem_wdata;
    logic [1:0][15:0] d_mem_addr;
    logic [1:0]       d_cpu_ready, d_cpu_grant, d_dma_ready, d_dma_grant;
    logic [1:0]       d_mem_r, d_mem_w, d_bus_err;

    int n_checks = 0;
    int n_errs = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_CYCLES(W0), .MAX_BURST(MB0)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_r(cpu_r), .cpu_w(cpu_w),
        .cpu_rdata(d_cpu_rdata[0]), .cpu_ready(d_cpu_ready[0]), .cpu_grant(d_cpu_grant[0]),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_r(dma_r), .dma_w(dma_w),
        .dma_rdata(d_dma_rdata[0]), .dma_ready(d_dma_ready[0]), .dma_grant(d_dma_grant[0]),
        .mem_addr(d_mem_addr[0]), .mem_wdata(d_mem_wdata[0]), .mem_rdata(mem_rdata),
        .mem_r(d_mem_r[0]), .mem_w(d_mem_w[0]), .bus_err(d_bus_err[0])
    );

    bus_arbiter #(.WAIT_CYCLES(W1), .MAX_BURST(MB1)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_r(cpu_r), .cpu_w(cpu_w),
        .cpu_rdata(d_cpu_rdata[1]), .cpu_ready(d_cpu_ready[1]), .cpu_grant(d_cpu_grant[1]),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_r(dma_r), .dma_w(dma_w),
        .dma_rdata(d_dma_rdata[1]), .dma_ready(d_dma_ready[1]), .dma_grant(d_dma_grant[1]),
        .mem_addr(d_mem_addr[1]), .mem_wdata(d_mem_wdata[1]), .mem_rdata(mem_rdata),
        .mem_r(d_mem_r[1]), .mem_w(d_mem_w[1]), .bus_err(d_bus_err[1])
    );

    // Expected outputs per cycle; cycle k is the interval following posedge k after reset release.
    typedef struct packed {
        bit        mr, mw, cg, dg, cr, dr, err;
        bit [15:0] addr;
        bit [7:0]  wd;
    } exp_t;

    exp_t     expv [0:1][0:ASZ-1];
    int       nxt [0:1];
    bit       ten [0:1];
    int       own [0:1];
    int       cnt [0:1];
    int       last [0:1];
    int       cap_edge [0:1];
    int       cap_own [0:1];
    bit [7:0] m_rd [0:1][0:1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < ASZ; t++) expv[i][t] = '0;
            nxt[i] = 1; ten[i] = 1'b0; own[i] = 0; cnt[i] = 0; last[i] = 1;
            cap_edge[i] = -1; cap_own[i] = 0;
            m_rd[i][0] = 8'h00; m_rd[i][1] = 8'h00;
        end
    endtask

    // Book one transfer granted at edge n: strobes for W+1 cycles, then a ready cycle.
    task automatic m_start(input int i, input int o, input int n);
        int w, d;
        bit r, wr;
        bit [15:0] a;
        bit [7:0] wd;
        w  = (i == 0) ? W0 : W1;
        r  = (o == 1) ? dma_r : cpu_r;
        wr = (o == 1) ? dma_w : cpu_w;
        a  = (o == 1) ? dma_addr : cpu_addr;
        wd = (o == 1) ? dma_wdata : cpu_wdata;
        d  = (r != wr) ? n + w + 1 : n;
        for (int t = n; t <= d; t++) begin
            expv[i][t] = '0;
            expv[i][t].addr = a;
            expv[i][t].wd = wd;
            expv[i][t].cg = (o == 0);
            expv[i][t].dg = (o == 1);
            if (r != wr && t < d) begin
                expv[i][t].mr = r;
                expv[i][t].mw = wr;
            end
        end
        expv[i][d].cr = (o == 0);
        expv[i][d].dr = (o == 1);
        expv[i][d].err = (r == wr);
        if (r && !wr) begin
            cap_edge[i] = d;
            cap_own[i] = o;
        end
        nxt[i] = d + 1;
        ten[i] = 1'b1;
        own[i] = o;
    endtask

    task automatic m_step(input int i, input int k);
        int mb, o;
        bit oreq, xreq;
        mb = (i == 0) ? MB0 : MB1;
        if (cap_edge[i] == k) m_rd[i][cap_own[i]] = mem_rdata;
        if (k != nxt[i]) return;
        if (ten[i]) begin
            oreq = (own[i] == 1) ? dma_req : cpu_req;
            xreq = (own[i] == 1) ? cpu_req : dma_req;
            if (oreq && (cnt[i] < mb || !xreq)) begin
                if (cnt[i] < mb) cnt[i]++;
                m_start(i, own[i], k);
            end else begin
                ten[i] = 1'b0;
                nxt[i] = k + 1;
            end
            return;
        end
        if (cpu_req || dma_req) begin
            if (cpu_req && dma_req) o = (last[i] == 1) ? 0 : 1;
            else o = dma_req ? 1 : 0;
            last[i] = o;
            cnt[i] = 1;
            m_start(i, o, k);
        end else begin
            nxt[i] = k + 1;
        end
    endtask

    task automatic compare(input int i, input int k);
        exp_t e;
        e = expv[i][k];
        chk($sformatf("i%0d strobes c%0d", i, k), 64'({d_mem_r[i], d_mem_w[i]}), 64'({e.mr, e.mw}));
        chk($sformatf("i%0d exclusive c%0d", i, k), 64'(d_mem_r[i] & d_mem_w[i]), 64'd0);
        chk($sformatf("i%0d mem_addr c%0d", i, k), 64'(d_mem_addr[i]), 64'(e.addr));
        chk($sformatf("i%0d mem_wdata c%0d", i, k), 64'(d_mem_wdata[i]), 64'(e.wd));
        chk($sformatf("i%0d grants c%0d", i, k), 64'({d_cpu_grant[i], d_dma_grant[i]}), 64'({e.cg, e.dg}));
        chk($sformatf("i%0d ready/err c%0d", i, k),
            64'({d_cpu_ready[i], d_dma_ready[i], d_bus_err[i]}), 64'({e.cr, e.dr, e.err}));
        chk($sformatf("i%0d cpu_rdata c%0d", i, k), 64'(d_cpu_rdata[i]), 64'(m_rd[i][0]));
        chk($sformatf("i%0d dma_rdata c%0d", i, k), 64'(d_dma_rdata[i]), 64'(m_rd[i][1]));
    endtask

    task automatic zero_chk(input string tag);
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s i%0d", tag, i),
                64'({d_mem_addr[i], d_mem_wdata[i], d_mem_r[i], d_mem_w[i], d_cpu_grant[i],
                     d_dma_grant[i], d_cpu_ready[i], d_dma_ready[i], d_bus_err[i],
                     d_cpu_rdata[i], d_dma_rdata[i]}), 64'd0);
    endtask

    function automatic logic [1:0] rnd_rw();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return 2'b11;
        if (s == 1) return 2'b00;
        return (s % 2 == 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic drv(input int k);
        mem_rdata = 8'($urandom);
        if (k < 80) begin
            cpu_req = 1'b1; cpu_r = 1'b0; cpu_w = 1'b1; cpu_addr = 16'h1000; cpu_wdata = 8'h55;
            dma_req = 1'b1; dma_r = 1'b1; dma_w = 1'b0; dma_addr = 16'h3000; dma_wdata = 8'($urandom);
        end else begin
            cpu_req = ($urandom_range(0, 3) != 0);
            {cpu_r, cpu_w} = rnd_rw();
            cpu_addr = 16'($urandom);
            cpu_wdata = 8'($urandom);
            dma_req = ($urandom_range(0, 3) != 0);
            {dma_r, dma_w} = rnd_rw();
            dma_addr = 16'($urandom);
            dma_wdata = 8'($urandom);
        end
    endtask

    initial begin
        int t;
        cpu_req = 0; cpu_r = 0; cpu_w = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_r = 0; dma_w = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        m_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        zero_chk("reset state");
        drv(1);
        reset = 1'b1;

        for (int k = 1; k <= NCYC; k++) begin
            @(posedge clk);
            m_step(0, k);
            m_step(1, k);
            @(negedge clk);
            compare(0, k);
            compare(1, k);
            drv(k + 1);
        end

        reset = 1'b0;
        #1 zero_chk("reset after run");
        @(negedge clk);
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_r = 1'b0; dma_w = 1'b1; dma_addr = 16'h4000; dma_wdata = 8'h66;
        reset = 1'b1;
        t = 0;
        while (!d_mem_w[0] && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("dma write strobe", 64'(d_mem_w[0]), 64'd1);
        chk("dma write addr", 64'(d_mem_addr[0]), 64'h4000);
        reset = 1'b0;
        #1 zero_chk("reset mid access");
        repeat (2) begin
            @(negedge clk);
            zero_chk("reset held");
        end
        cpu_req = 1'b1; cpu_r = 1'b1; cpu_w = 1'b0; cpu_addr = 16'h2000;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("first grant after reset i0", 64'({d_cpu_grant[0], d_dma_grant[0]}), 64'b10);
        chk("first grant after reset i1", 64'({d_cpu_grant[1], d_dma_grant[1]}), 64'b10);
        chk("first read strobe after reset", 64'({d_mem_r[0], d_mem_w[0]}), 64'b10);
        chk("first read addr after reset", 64'(d_mem_addr[0]), 64'h2000);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra memory wait cycles per transfer (range 0-7).
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning the maximum back-to-back transfers per grant while the other requester waits (range 1-15).
REQ-003 SHALL have ports clk in 1 (clock) and reset in 1 (asynchronous, active-low).
REQ-004 SHALL have ports cpu_req in 1, cpu_addr in 16, cpu_wdata in 8, cpu_r in 1, cpu_w in 1: the CPU transfer request.
REQ-005 SHALL have ports cpu_rdata out 8, cpu_ready out 1, cpu_grant out 1: the CPU read data, completion pulse and ownership indicator.
REQ-006 SHALL have ports dma_req, dma_addr, dma_wdata, dma_r, dma_w, dma_rdata, dma_ready and dma_grant, with the same widths and meanings as the CPU set.
REQ-007 SHALL have ports mem_addr out 16, mem_wdata out 8, mem_rdata in 8, mem_r out 1, mem_w out 1: the shared memory bus.
REQ-008 SHALL have port bus_err out 1: a one-cycle pulse when a transfer is rejected.

Function
REQ-009 SHALL implement states IDLE, ACCESS and DONE; all outputs SHALL be registered on posedge clk.
REQ-010 SHALL, in IDLE, grant the requester whose req is high; when both are high, it SHALL grant the one not granted last (round-robin).
REQ-011 SHALL initialise last_grant to DMA at reset, so the CPU wins the first tie.
REQ-012 SHALL, on grant, latch the owner's addr, wdata, r and w, set the owner's grant, and enter ACCESS on the next edge.
REQ-013 SHALL hold mem_addr and mem_wdata from the latched values and assert mem_r or mem_w for exactly WAIT_CYCLES+1 cycles while in ACCESS.
REQ-014 SHALL, on the last ACCESS cycle of a read, capture mem_rdata into the owner's rdata register, which holds its value until the next read by that owner.
REQ-015 SHALL, in DONE, deassert mem_r and mem_w and pulse the owner's ready for one cycle.
REQ-016 Latency: req sampled high at edge N gives ACCESS from N+1 to N+1+WAIT_CYCLES, and ready high in cycle N+2+WAIT_CYCLES.
REQ-017 SHALL, from DONE, return to ACCESS directly (burst) with newly latched owner inputs if the owner's req is still high and either burst_cnt < MAX_BURST or the other req is low; otherwise it SHALL go to IDLE.
REQ-018 SHALL set burst_cnt to 1 on a grant from IDLE and increment it on each burst continuation, saturating at MAX_BURST.
REQ-019 SHALL drop grant in IDLE; a waiting requester is therefore granted within at most MAX_BURST*(WAIT_CYCLES+2)+1 cycles.
REQ-020 SHALL treat a latched request with r=w=1 or r=w=0 as illegal: skip ACCESS, go to DONE with no strobe, pulse ready together with bus_err, and leave rdata unchanged.
REQ-021 SHALL ignore a requester's inputs while it is not granted; dropping req mid-ACCESS SHALL NOT abort the transfer.
REQ-022 SHALL keep mem_r and mem_w mutually exclusive at all times.
REQ-023 SHALL drive mem_addr, mem_wdata, mem_r and mem_w to 0 in IDLE.

Reset
REQ-024 SHALL, on reset low, immediately (asynchronously) force state IDLE, mem_r=mem_w=0, mem_addr=mem_wdata=0, both grants, both readys and bus_err to 0, cpu_rdata=dma_rdata=0, burst_cnt=0 and last_grant=DMA.
REQ-025 SHALL abort any transfer in progress at reset mid-ACCESS, with no ready pulse issued.
REQ-026 SHALL begin arbitration on the first posedge after reset rises.

Verification
REQ-027 CPU read, WAIT_CYCLES=1: cpu_req=1, cpu_r=1, addr 2000h, mem_rdata=A5h -> mem_r high 2 cycles with mem_addr=2000h, cpu_ready pulses in cycle N+3, cpu_rdata=A5h.
REQ-028 Simultaneous requests after reset: CPU write 55h@1000h and DMA read @3000h -> CPU is served first, then DMA; mem_w and mem_r are never high together.
REQ-029 Burst fairness, MAX_BURST=4: CPU holds req for 10 transfers while DMA requests -> exactly 4 CPU readys, then a DMA grant, then CPU resumes.
REQ-030 Illegal request: cpu_r=cpu_w=1 -> no mem strobe; cpu_ready and bus_err pulse together 1 cycle after grant.
REQ-031 Reset mid-ACCESS: reset low during a DMA write -> mem_w=0 in the same cycle, no dma_ready; after release, a pending CPU request is granted first.
REQ-032 WAIT_CYCLES=0, single DMA read -> mem_r high exactly 1 cycle; dma_ready pulses in cycle N+2.
